// File: rtl/sub_borrow_serial.sv
// sub_borrow_serial: bit-serial subtractor, diff = a - b, LSB first,
// one bit per clock, with start/ready/done_tick handshake and
// borrow, signed-overflow and zero flags.
module sub_borrow_serial #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         ready,
    output logic         done_tick,
    output logic [N-1:0] diff,
    output logic         bout,
    output logic         ovf,
    output logic         zero
);

    localparam int CW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE,
        OP,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    // Only the first N-1 result bits need storage; the last bit is
    // appended directly when the final diff is loaded.
    logic [N-2:0]  res_q, res_d;
    logic          br_q, br_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          as_q, as_d;
    logic          bs_q, bs_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          bout_q, bout_d;
    logic          ovf_q, ovf_d;
    logic          zero_q, zero_d;

    logic          d_bit;
    logic          br_next;
    logic [N-1:0]  res_w;

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            as_q    <= 1'b0;
            bs_q    <= 1'b0;
            diff_q  <= '0;
            bout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            br_q    <= br_d;
            cnt_q   <= cnt_d;
            as_q    <= as_d;
            bs_q    <= bs_d;
            diff_q  <= diff_d;
            bout_q  <= bout_d;
            ovf_q   <= ovf_d;
            zero_q  <= zero_d;
        end
    end

    // Next-state logic: capture in IDLE, one subtract bit per OP cycle,
    // results and flags loaded on the final-bit edge.
    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        br_d    = br_q;
        cnt_d   = cnt_q;
        as_d    = as_q;
        bs_d    = bs_q;
        diff_d  = diff_q;
        bout_d  = bout_q;
        ovf_d   = ovf_q;
        zero_d  = zero_q;

        d_bit   = a_q[0] ^ b_q[0] ^ br_q;
        br_next = (~a_q[0] & b_q[0]) | (~(a_q[0] ^ b_q[0]) & br_q);
        res_w   = {d_bit, res_q};

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    as_d    = a[N-1];
                    bs_d    = b[N-1];
                    br_d    = 1'b0;
                    cnt_d   = '0;
                    state_d = OP;
                end
            end
            OP: begin
                br_d  = br_next;
                res_d = res_w[N-1:1];
                a_d   = a_q >> 1;
                b_d   = b_q >> 1;
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(N - 1)) begin
                    state_d = DONE;
                    diff_d  = res_w;
                    bout_d  = br_next;
                    ovf_d   = (as_q != bs_q) && (d_bit != as_q);
                    zero_d  = (res_w == '0);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign ready     = (state_q == IDLE);
    assign done_tick = (state_q == DONE);
    assign diff      = diff_q;
    assign bout      = bout_q;
    assign ovf       = ovf_q;
    assign zero      = zero_q;

endmodule
